// File: rtl/tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_arb_pkg
// Purpose  : Shared types and constants for the UART TX link arbiter.
//            Holds the arbiter state encoding, the default watchdog limit
//            and the supported requester-count range.
// Revision : 1.0 - initial release
// ============================================================================
package tx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } tx_arb_state_t;

  localparam int c_to_cyc_def = 50000;
  localparam int c_nreq_min   = 2;
  localparam int c_nreq_max   = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Returns the first set
//            request bit at or after index (i_ptr+1) mod NREQ.
// Ports    : i_req    - request vector
//            i_ptr    - index of the previous winner
//            o_onehot - one-hot form of the pick (zero when nothing set)
//            o_idx    - index form of the pick (zero when nothing set)
//            o_any    - at least one request bit is set
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_cand;

  // Walk candidates from farthest to nearest so the nearest set bit after
  // the pointer is the last one written and therefore wins.
  always_comb begin
    w_cand = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
    end
    o_onehot = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/tx_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_link_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NREQ
//            packet senders. A winner keeps the link for a whole packet;
//            its byte strobes/data are relayed to the UART and the UART's
//            end-of-byte is routed back to the winner only.
// Option   : TX_ARB_TIMEOUT_EN - builds a watchdog that aborts a grant
//            stalled for TO_CYC cycles in GRANT or WAIT and pulses tout.
// Ports    : clk, rst (async, active low)
//            req/stb/last/din - per-requester request, byte strobe,
//                               last-byte flag, byte data
//            eoTx             - end-of-byte pulse from the UART
//            gnt/done         - per-requester grant and end-of-byte pulse
//            stTx/tx_data     - start pulse and byte to the UART
//            busy/tout        - not idle / watchdog abort pulse
// Revision : 1.0 - initial release
// ============================================================================
module tx_link_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int TO_CYC = c_to_cyc_def
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  stb,
  input  logic [NREQ-1:0]  last,
  input  logic [NREQ*DW-1:0] din,
  input  logic             eoTx,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             stTx,
  output logic [DW-1:0]    tx_data,
  output logic             busy,
  output logic             tout
);

  localparam int c_iw = $clog2(NREQ);

  tx_arb_state_t   r_state;
  tx_arb_state_t   w_nstate;
  logic [c_iw-1:0] r_g;
  logic [NREQ-1:0] r_g_oh;
  logic [c_iw-1:0] r_ptr;
  logic            r_last;
  logic [DW-1:0]   r_tx_data;
  logic [NREQ-1:0] r_done;

  logic [NREQ-1:0] w_pick_oh;
  logic [c_iw-1:0] w_pick_idx;
  logic            w_any;
  logic            w_stb_g;
  logic            w_req_g;
  logic            w_last_g;
  logic [DW-1:0]   w_din_g;
  logic            w_to_hit;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_iw)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_oh),
    .o_idx    (w_pick_idx),
    .o_any    (w_any)
  );

  // Only the grant holder's lines matter; everyone else is ignored.
  assign w_stb_g  = stb[r_g];
  assign w_req_g  = req[r_g];
  assign w_last_g = last[r_g];
  assign w_din_g  = din[r_g*DW +: DW];

`ifdef TX_ARB_TIMEOUT_EN
  localparam int              c_cw      = $clog2(TO_CYC + 1);
  localparam logic [c_cw-1:0] c_to_last = c_cw'(TO_CYC - 1);

  logic [c_cw-1:0] r_cnt;
  logic            r_tout;
  logic            w_to_fire;

  assign w_to_hit = ((r_state == ST_GRANT) || (r_state == ST_WAIT)) &&
                    (r_cnt == c_to_last);

  // A real exit event on the terminal cycle takes precedence over the abort.
  assign w_to_fire = w_to_hit &&
                     ((r_state == ST_GRANT) ? (w_req_g && !w_stb_g) : !eoTx);

  // Counter restarts whenever GRANT or WAIT is (re)entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tout <= 1'b0;
    end else begin
      if (((r_state == ST_GRANT) || (r_state == ST_WAIT)) && (w_nstate == r_state))
        r_cnt <= r_cnt + c_cw'(1);
      else
        r_cnt <= '0;
      r_tout <= w_to_fire;
    end
  end

  assign tout = r_tout;
`else
  logic w_unused_to;

  assign w_to_hit    = 1'b0;
  assign tout        = 1'b0;
  assign w_unused_to = (TO_CYC > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    gnt      = '0;
    stTx     = 1'b0;
    busy     = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_any)
          w_nstate = ST_GRANT;
      end
      ST_GRANT: begin
        gnt = r_g_oh;
        if (w_stb_g)
          w_nstate = ST_START;
        else if (!w_req_g || w_to_hit)
          w_nstate = ST_RELEASE;
      end
      ST_START: begin
        gnt      = r_g_oh;
        stTx     = 1'b1;
        w_nstate = ST_WAIT;
      end
      ST_WAIT: begin
        gnt = r_g_oh;
        if (eoTx)
          w_nstate = (r_last || !w_req_g) ? ST_RELEASE : ST_GRANT;
        else if (w_to_hit)
          w_nstate = ST_RELEASE;
      end
      ST_RELEASE: w_nstate = ST_IDLE;
      default: begin
        busy     = 1'b0;
        w_nstate = ST_IDLE;
      end
    endcase
  end

  // ptr resets to NREQ-1 so requester 0 is the first candidate after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g       <= '0;
      r_g_oh    <= '0;
      r_ptr     <= c_iw'(NREQ - 1);
      r_last    <= 1'b0;
      r_tx_data <= '0;
      r_done    <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any) begin
        r_g    <= w_pick_idx;
        r_g_oh <= w_pick_oh;
      end
      if ((r_state == ST_GRANT) && w_stb_g) begin
        r_tx_data <= w_din_g;
        r_last    <= w_last_g;
      end
      if (r_state == ST_RELEASE)
        r_ptr <= r_g;
      r_done <= ((r_state == ST_WAIT) && eoTx) ? r_g_oh : '0;
    end
  end

  assign tx_data = r_tx_data;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_link_arbiter
// Purpose  : Self-checking bench for tx_link_arbiter (NREQ=4, DW=8,
//            TO_CYC=16). Cycle vector table, directed packet sequences,
//            and a randomized run against a transaction-level model.
// Option   : TX_ARB_TIMEOUT_EN - also exercises the watchdog abort.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_link_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req, stb, last, gnt, done;
  logic [31:0] din;
  logic        eoTx, stTx, busy, tout;
  logic [7:0]  tx_data;

  int total = 0;
  int bad   = 0;
  int tout_seen = 0;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int c_lat_long = 10;
  localparam int c_tout_exp = 1;
`else
  localparam int c_lat_long = 20;
  localparam int c_tout_exp = 0;
`endif

  tx_link_arbiter #(.NREQ(4), .DW(8), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .req(req), .stb(stb), .last(last), .din(din),
    .eoTx(eoTx), .gnt(gnt), .done(done), .stTx(stTx), .tx_data(tx_data),
    .busy(busy), .tout(tout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tout === 1'b1) tout_seen++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; req = '0; stb = '0; last = '0; din = '0; eoTx = 1'b0;
    tick; tick;
    rst = 1'b1;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Expected winner: first requester after the previous winner, cyclically.
  function automatic int rr_next(input logic [3:0] r, input int lw);
    for (int k = 1; k <= 4; k++) if (r[(lw + k) % 4]) return (lw + k) % 4;
    return -1;
  endfunction

  task automatic wait_gnt(output int idx);
    int n = 0;
    while (gnt == 4'b0 && n < 50) begin tick; n++; end
    chk("grant_seen", 32'(gnt != 4'b0), 1);
    idx = oh2i(gnt);
  endtask

  task automatic send_byte(input int r, input logic [7:0] b, input logic lst, input int lat);
    int n = 0;
    while (!gnt[r] && n < 60) begin tick; n++; end
    chk("byte_gnt", 32'(gnt[r]), 1);
    din = '0; din[r*8 +: 8] = b; stb[r] = 1'b1; last[r] = lst;
    tick;
    stb = '0; last = '0; din = '0;
    chk("byte_stTx", 32'(stTx), 1);
    chk("byte_tx_data", 32'(tx_data), 32'(b));
    tick;
    chk("byte_stTx_pulse", 32'(stTx), 0);
    repeat (lat - 1) tick;
    chk("byte_tx_hold", 32'(tx_data), 32'(b));
    eoTx = 1'b1;
    tick;
    eoTx = 1'b0;
    chk("byte_done", 32'(done), 32'(4'(1) << r));
  endtask

  typedef struct {
    logic [3:0]  req, stb, last;
    logic [31:0] din;
    logic        eo;
    logic [3:0]  gnt, done;
    logic        st, busy;
    logic [7:0]  txd;
  } vec_t;

  vec_t tv [15];

  task automatic run_random(input int ncyc);
    int pk[4];
    int bl[4];
    int cur = -1, lw = 3, ucnt = 0, n_st = 0, n_done = 0, w, left;
    bit can_stb = 0, pend = 0, eo_sent = 0, seen_st = 0;
    logic [7:0] exp_b = '0;
    logic [3:0] prev_gnt = '0, drv_req;
    do_reset;
    for (int i = 0; i < 4; i++) begin pk[i] = $urandom_range(0, 2); bl[i] = 0; end
    for (int c = 0; c < ncyc; c++) begin
      stb = '0; last = '0; din = $urandom; eoTx = 1'b0;
      if (c < ncyc - 600)
        for (int i = 0; i < 4; i++)
          if (pk[i] == 0 && $urandom_range(0, 7) == 0) pk[i] = $urandom_range(1, 2);
      for (int i = 0; i < 4; i++) drv_req[i] = (pk[i] > 0);
      req = drv_req;
      w = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0 && w != cur) stb[w] = 1'b1;
      if (cur >= 0 && can_stb && $urandom_range(0, 3) != 0) begin
        exp_b = 8'($urandom);
        din[cur*8 +: 8] = exp_b;
        stb[cur] = 1'b1;
        last[cur] = (bl[cur] == 1);
        can_stb = 0; pend = 1; seen_st = 0;
      end else if (pend && seen_st && !eo_sent) begin
        ucnt--;
        if (ucnt == 0) begin eoTx = 1'b1; eo_sent = 1; end
      end else if (!pend && $urandom_range(0, 7) == 0) begin
        eoTx = 1'b1;
      end
      tick;
      chk("rnd_gnt_onehot", 32'($onehot0(gnt)), 1);
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        w = oh2i(gnt);
        chk("rnd_winner", w, rr_next(drv_req, lw));
        cur = w; lw = w;
        bl[w] = $urandom_range(1, 3);
        can_stb = 1;
      end
      if (stTx) begin
        n_st++;
        chk("rnd_stTx_expected", 32'(pend && !seen_st), 1);
        chk("rnd_tx_data", 32'(tx_data), 32'(exp_b));
        seen_st = 1;
        ucnt = $urandom_range(2, 6);
      end
      if (done != 4'b0) begin
        n_done++;
        chk("rnd_done_expected", 32'(eo_sent), 1);
        if (cur >= 0) begin
          chk("rnd_done_route", 32'(done), 32'(4'(1) << cur));
          pend = 0; eo_sent = 0;
          bl[cur]--;
          if (bl[cur] <= 0) begin
            pk[cur]--;
            chk("rnd_release", 32'(gnt), 0);
          end else begin
            can_stb = 1;
          end
        end
      end
      prev_gnt = gnt;
    end
    left = pk[0] + pk[1] + pk[2] + pk[3];
    chk("rnd_drained", left, 0);
    chk("rnd_idle_end", 32'(busy), 0);
    chk("rnd_done_count", n_done, n_st);
  endtask

  initial begin
    int w;
    req = '0; stb = '0; last = '0; din = '0; eoTx = 1'b0;

    // Vector table: inputs for the next edge, outputs expected just after it.
    //            req      stb      last     din           eo    gnt      done     st    busy  txd
    tv[0]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{4'b0100, 4'b0100, 4'b0000, 32'h0041_0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h00};
    tv[2]  = '{4'b0100, 4'b0010, 4'b0000, 32'h0000_FF00, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h00};
    tv[3]  = '{4'b0100, 4'b0100, 4'b0000, 32'h0041_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'h41};
    tv[4]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h41};
    tv[5]  = '{4'b0100, 4'b0100, 4'b0000, 32'h0099_0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h41};
    tv[6]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b1, 8'h41};
    tv[7]  = '{4'b0100, 4'b0100, 4'b0100, 32'h0042_0000, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 8'h42};
    tv[8]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b1, 8'h42};
    tv[9]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 8'h42};
    tv[10] = '{4'b0011, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h42};
    tv[11] = '{4'b0011, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'h42};
    tv[12] = '{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'h42};
    tv[13] = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'h42};
    tv[14] = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 8'h42};

    // Reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_stTx", 32'(stTx), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tout", 32'(tout), 0);
    tick; tick;
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      req = tv[i].req; stb = tv[i].stb; last = tv[i].last; din = tv[i].din; eoTx = tv[i].eo;
      tick;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tv[i].done));
      chk($sformatf("vec%0d_stTx", i), 32'(stTx), 32'(tv[i].st));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tv[i].txd));
      chk($sformatf("vec%0d_tout", i), 32'(tout), 0);
    end

    // Single requester, three-byte packet
    do_reset;
    req = 4'b0100;
    send_byte(2, 8'h41, 1'b0, c_lat_long);
    send_byte(2, 8'h42, 1'b0, c_lat_long);
    send_byte(2, 8'h43, 1'b1, c_lat_long);
    chk("single_gnt_clear", 32'(gnt), 0);
    req = 4'b0000;
    tick;
    chk("single_gnt_low", 32'(gnt), 0);
    chk("single_idle", 32'(busy), 0);

    // Fairness with every requester asking
    do_reset;
    req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_gnt(w);
      chk("fair_order", w, p % 4);
      if (w >= 0) send_byte(w, 8'(8'h10 + p), 1'b1, 2);
    end
    req = 4'b0000;

    // Request dropped in WAIT before the last byte
    do_reset;
    req = 4'b0001;
    wait_gnt(w);
    din = 32'h55; stb = 4'b0001;
    tick;
    stb = '0; din = '0;
    chk("drop_stTx", 32'(stTx), 1);
    tick;
    req = 4'b0000;
    tick;
    eoTx = 1'b1;
    tick;
    eoTx = 1'b0;
    chk("drop_done", 32'(done), 32'h1);
    chk("drop_gnt", 32'(gnt), 0);
    tick;
    chk("drop_idle", 32'(busy), 0);

    // Reset during the WAIT of byte 2
    do_reset;
    req = 4'b0110;
    wait_gnt(w);
    chk("rst_first_grant", w, 1);
    send_byte(1, 8'hA1, 1'b0, 3);
    din = 32'h0000_A200; stb = 4'b0010;
    tick;
    stb = '0; din = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_stTx", 32'(stTx), 0);
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tout", 32'(tout), 0);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0111;
    wait_gnt(w);
    chk("midrst_next_grant", w, 0);
    req = 4'b0000;

`ifdef TX_ARB_TIMEOUT_EN
    // Watchdog: UART never answers
    begin
      int c = 0;
      do_reset;
      req = 4'b0011;
      wait_gnt(w);
      chk("wd_first_grant", w, 0);
      din = 32'h77; stb = 4'b0001;
      tick;
      stb = '0; din = '0;
      tick;
      while (!tout && c < 40) begin tick; c++; end
      chk("wd_delay", c, 16);
      chk("wd_gnt_drop", 32'(gnt), 0);
      tick;
      chk("wd_tout_pulse", 32'(tout), 0);
      wait_gnt(w);
      chk("wd_next_grant", w, 1);
      req = 4'b0000;
    end
`endif

    run_random(3000);

    chk("tout_pulses", tout_seen, c_tout_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
